spi_slave_fsm: RTL and testbench
================================

# spi_slave_fsm

Parametrised control FSM for the SPI slave memory interface. Sits between the input-conditioned SPI pins and the shift register, address latch and data memory. Decodes an address phase, a read/write bit and a data phase of configurable widths, and generates their write-enable and MISO tristate controls. Extends the fixed 7-bit-address, 8-bit-data controller with:

- generic widths;
- a counter-based state machine;
- an asynchronous reset;
- a terminal hold state;
- an optional burst mode with address auto-increment.

## Interface
- ADDR_WIDTH, 7, address bits per transaction (≥1)
- DATA_WIDTH, 8, data bits per word (≥2)
- sclk  in  1  SPI clock (conditioned posedge); sole clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  chip select, active low, sampled on sclk posedge
- sout  in  1  shift-register LSB (most recently shifted MOSI bit)
- miso_buff  out  1  MISO tristate enable
- dm_we  out  1  data-memory write enable
- addr_we  out  1  address-latch write enable
- sr_we  out  1  shift-register parallel-load enable
- addr_inc  out  1  address-latch increment pulse (burst only)

## Operation
- All outputs are registered. A value set on edge k is visible from edge k until edge k+1.
- Edge numbering: edge n is the n-th sclk posedge with cs=0 after cs was high or reset.
- States: IDLE, GET_ADDR, GOT_ADDR, WRITE_DATA, SAVE_TO_DM, READ_LOAD, READ_SHIFT, DONE.
- Bit counter width is $clog2(max(ADDR_WIDTH+1, DATA_WIDTH)+1). It clears on every state change.
- IDLE: on edge 1, go to GET_ADDR.
- GET_ADDR: covers edges 1..ADDR_WIDTH+1 (address bits, then the R/W bit). Go to GOT_ADDR after edge ADDR_WIDTH+1.
- GOT_ADDR, edge A=ADDR_WIDTH+2:
  - Set addr_we=1.
  - Sample sout. If sout=1, go to READ_LOAD; otherwise go to WRITE_DATA.
- WRITE_DATA: covers edges A+1..A+DATA_WIDTH, with all outputs 0. Then go to SAVE_TO_DM.
- SAVE_TO_DM, edge A+DATA_WIDTH+1: set dm_we=1. Then go to DONE.
- READ_LOAD: set sr_we=1. Then go to READ_SHIFT.
- READ_SHIFT: DATA_WIDTH edges with miso_buff=1. Then go to DONE.
- DONE: all outputs 0. Hold until cs=1. No retrigger while cs stays low.
- cs=1 at any posedge, in any state: go to IDLE with all outputs 0 on that edge. A transaction is aborted mid-address or mid-data, and no dm_we is issued for a partial word.
- reset=1: immediately (no clock needed) state=IDLE, counter=0, all five outputs 0. Reset dominates cs.
- An unreachable state encoding goes to IDLE with outputs 0 on the next edge.
- At most one of dm_we, addr_we, sr_we is high in any cycle. addr_inc may coincide with dm_we.

## Timing
- Defaults (A=9):
  - addr_we is high edge 9→10.
  - Write: dm_we is high edge 18→19.
  - Read: sr_we is high edge 10→11; miso_buff is high edges 11→19 (8 cycles).
- Write latency, first edge to dm_we: ADDR_WIDTH+DATA_WIDTH+3 edges.
- Read latency, first edge to first MISO bit: ADDR_WIDTH+4 edges.
- Burst word period is DATA_WIDTH+1 edges in both directions. For reads, the master discards the reload slot, where miso_buff=0.

## Configuration
- SPI_FSM_BURST_EN defined (burst mode):
  - Write: SAVE_TO_DM also sets addr_inc=1 and returns to WRITE_DATA, not DONE.
  - Read: the last READ_SHIFT edge sets addr_inc=1 and goes to READ_LOAD. miso_buff=0 during the READ_LOAD cycle, so the next sr_we loads from the incremented address.
  - The burst continues until cs=1.
- SPI_FSM_BURST_EN undefined: addr_inc is tied to 0 and one word is transferred per cs assertion.

## Test plan
- Reset mid-read: assert reset between edges 12 and 13 → all outputs 0 immediately. After release with cs low, the next edge restarts as edge 1.
- Write, defaults, addr 0x15, R/W=0, data 0xA5 → addr_we only on 9→10, dm_we only on 18→19, miso_buff never 1, then DONE until cs rises.
- Read, defaults, R/W=1 → sr_we on 10→11, miso_buff on 11→19 (exactly 8 cycles), dm_we never 1.
- Abort: cs=1 at edge 14 of a write → outputs 0, no dm_we. The next cs-low frame behaves as a fresh transaction.
- ADDR_WIDTH=4, DATA_WIDTH=16 write → addr_we on 6→7, dm_we on 23→24.
- With SPI_FSM_BURST_EN, 3-word write → dm_we+addr_inc on edges 18, 27 and 36. 2-word read → addr_inc on 18→19, sr_we on 10 and 19, miso_buff low 19→20.

Source files
------------

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: SPI slave control FSM with a parametrised address phase, a
// R/W bit and a data phase. It drives the address latch, data memory, shift
// register load and MISO tristate enable. All outputs are registered.
//
// Optional feature macro: SPI_FSM_BURST_EN
//   defined   -> burst mode: address auto-increment, words repeat until cs=1
//   undefined -> one word per cs assertion, addr_inc tied low
//
// state      | meaning
// IDLE       | waiting for the first sclk edge with cs low
// GET_ADDR   | shifting address bits and the R/W bit
// GOT_ADDR   | latch address, sample R/W from sout
// WRITE_DATA | shifting in one write data word
// SAVE_TO_DM | write the received word to data memory
// READ_LOAD  | parallel-load the shift register from memory
// READ_SHIFT | driving read data onto MISO
// DONE       | transfer complete, hold until cs rises
module spi_slave_fsm #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic sclk,
    input  logic reset,
    input  logic cs,
    input  logic sout,
    output logic miso_buff,
    output logic dm_we,
    output logic addr_we,
    output logic sr_we,
    output logic addr_inc
);

    localparam int CNT_MAX = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts: the counter starts at 0 on the first edge spent in a state.
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GET_ADDR   = 3'd1,
        GOT_ADDR   = 3'd2,
        WRITE_DATA = 3'd3,
        SAVE_TO_DM = 3'd4,
        READ_LOAD  = 3'd5,
        READ_SHIFT = 3'd6,
        DONE       = 3'd7
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;

`ifndef SPI_FSM_BURST_EN
    assign addr_inc = 1'b0;
`endif

    // Sequencer: next state, bit counter and registered strobes in one block.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            miso_buff <= 1'b0;
            dm_we     <= 1'b0;
            addr_we   <= 1'b0;
            sr_we     <= 1'b0;
`ifdef SPI_FSM_BURST_EN
            addr_inc  <= 1'b0;
`endif
        end else begin
            miso_buff <= 1'b0;
            dm_we     <= 1'b0;
            addr_we   <= 1'b0;
            sr_we     <= 1'b0;
`ifdef SPI_FSM_BURST_EN
            addr_inc  <= 1'b0;
`endif
            bit_cnt   <= '0;

            if (cs) begin
                // Deselect aborts anything in flight; a partial word is never written.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        // This edge is already the first address bit.
                        state <= GET_ADDR;
                    end
                    GET_ADDR: begin
                        if (bit_cnt == ADDR_LAST) begin
                            state <= GOT_ADDR;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    GOT_ADDR: begin
                        addr_we <= 1'b1;
                        state   <= sout ? READ_LOAD : WRITE_DATA;
                    end
                    WRITE_DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            state <= SAVE_TO_DM;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    SAVE_TO_DM: begin
                        dm_we <= 1'b1;
`ifdef SPI_FSM_BURST_EN
                        addr_inc <= 1'b1;
                        state    <= WRITE_DATA;
`else
                        state    <= DONE;
`endif
                    end
                    READ_LOAD: begin
                        sr_we <= 1'b1;
                        state <= READ_SHIFT;
                    end
                    READ_SHIFT: begin
                        miso_buff <= 1'b1;
                        if (bit_cnt == DATA_LAST) begin
`ifdef SPI_FSM_BURST_EN
                            // Reload slot follows; master discards it.
                            addr_inc <= 1'b1;
                            state    <= READ_LOAD;
`else
                            state    <= DONE;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: scoreboard bench for spi_slave_fsm. Two instances run the
// same cs/reset frames: defaults (7/8) and ADDR_WIDTH=4/DATA_WIDTH=16. Expected
// per-edge output vectors come from closed-form timing formulas.
module tb_spi_slave_fsm;

    localparam int AW_A  = 7;
    localparam int DW_A  = 8;
    localparam int AW_B  = 4;
    localparam int DW_B  = 16;
    localparam int FRAME = 38;
`ifdef SPI_FSM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic sclk = 1'b0;
    logic reset;
    logic cs;
    logic sout_a, sout_b;
    logic miso_a, dm_a, adr_a, sr_a, inc_a;
    logic miso_b, dm_b, adr_b, sr_b, inc_b;

    // {miso_buff, dm_we, addr_we, sr_we, addr_inc}
    wire [4:0] out_a = {miso_a, dm_a, adr_a, sr_a, inc_a};
    wire [4:0] out_b = {miso_b, dm_b, adr_b, sr_b, inc_b};

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         edge_n;
        logic [4:0] va;
        logic [4:0] vb;
    } exp_t;
    exp_t sb[$];

    spi_slave_fsm #(.ADDR_WIDTH(AW_A), .DATA_WIDTH(DW_A)) u_a (
        .sclk(sclk), .reset(reset), .cs(cs), .sout(sout_a),
        .miso_buff(miso_a), .dm_we(dm_a), .addr_we(adr_a), .sr_we(sr_a), .addr_inc(inc_a)
    );

    spi_slave_fsm #(.ADDR_WIDTH(AW_B), .DATA_WIDTH(DW_B)) u_b (
        .sclk(sclk), .reset(reset), .cs(cs), .sout(sout_b),
        .miso_buff(miso_b), .dm_we(dm_b), .addr_we(adr_b), .sr_we(sr_b), .addr_inc(inc_b)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Expected outputs on frame edge n, derived from the documented edge timing.
    function automatic logic [4:0] exp_vec(input int n, input bit rw, input int aw, input int dw);
        logic miso, dm, adr, sr, inc;
        int a, w, l, p;
        miso = 1'b0; dm = 1'b0; adr = 1'b0; sr = 1'b0; inc = 1'b0;
        a = aw + 2;
        w = a + dw + 1;
        l = a + 1;
        adr = (n == a);
        if (!rw) begin
            if (BURST) begin
                if (n >= w && (n - w) % (dw + 1) == 0) begin
                    dm  = 1'b1;
                    inc = 1'b1;
                end
            end else begin
                dm = (n == w);
            end
        end else if (n >= l) begin
            p = (n - l) % (dw + 1);
            if (BURST) begin
                sr   = (p == 0);
                miso = (p != 0);
                inc  = (p == dw);
            end else begin
                sr   = (n == l);
                miso = (n > l) && (n <= l + dw);
            end
        end
        return {miso, dm, adr, sr, inc};
    endfunction

    // Shift-register LSB seen before edge k: the bit shifted in on edge k-1.
    function automatic logic stream_bit(input int k, input int aw, input int dw,
                                        input logic [31:0] addr, input bit rw,
                                        input logic [31:0] data);
        int i;
        i = k - 2;
        if (i < 0) return 1'b0;
        if (i < aw) return addr[aw-1-i];
        if (i == aw) return rw;
        if (i < aw + 1 + dw) return data[dw-1-(i-aw-1)];
        return 1'b0;
    endfunction

    // Drive n_edges cs-low edges; called and returns at a negedge.
    task automatic run_frame(input string name, input int n_edges, input bit rw_a, input bit rw_b,
                             input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        cs = 1'b0;
        for (int k = 1; k <= n_edges; k++) begin
            sout_a   = stream_bit(k, AW_A, DW_A, addr, rw_a, data);
            sout_b   = stream_bit(k, AW_B, DW_B, addr, rw_b, data);
            e.edge_n = k;
            e.va     = exp_vec(k, rw_a, AW_A, DW_A);
            e.vb     = exp_vec(k, rw_b, AW_B, DW_B);
            sb.push_back(e);
            @(posedge sclk);
            @(negedge sclk);
            e = sb.pop_front();
            check($sformatf("%s_a_e%0d", name, e.edge_n), out_a, e.va);
            check($sformatf("%s_b_e%0d", name, e.edge_n), out_b, e.vb);
        end
    endtask

    task automatic idle_edges(input string name, input int n);
        cs = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge sclk);
            @(negedge sclk);
            check($sformatf("%s_a_%0d", name, k), out_a, 5'b0);
            check($sformatf("%s_b_%0d", name, k), out_b, 5'b0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        cs     = 1'b1;
        sout_a = 1'b0;
        sout_b = 1'b0;
        #2;
        check("reset_a", out_a, 5'b0);
        check("reset_b", out_b, 5'b0);
        @(negedge sclk);
        reset = 1'b0;
        idle_edges("idle0", 2);

        run_frame("wr", FRAME, 1'b0, 1'b0, 32'h15, 32'hA5);
        idle_edges("wr_end", 2);

        run_frame("rd", FRAME, 1'b1, 1'b1, 32'h2A, 32'h3C);
        idle_edges("rd_end", 2);

        // Reset between edges 12 and 13 of a read, cs stays low.
        run_frame("rdrst", 12, 1'b1, 1'b1, 32'h11, 32'h00);
        #1 reset = 1'b1;
        #1;
        check("rst_async_a", out_a, 5'b0);
        check("rst_async_b", out_b, 5'b0);
        @(posedge sclk);
        @(negedge sclk);
        check("rst_hold_a", out_a, 5'b0);
        check("rst_hold_b", out_b, 5'b0);
        reset = 1'b0;
        run_frame("rdpost", FRAME, 1'b1, 1'b1, 32'h05, 32'hFF);
        idle_edges("rdpost_end", 2);

        // Abort a write with cs=1 at edge 14, then a fresh write.
        run_frame("ab", 13, 1'b0, 1'b0, 32'h7F, 32'hFF);
        idle_edges("ab_cs", 2);
        run_frame("wr2", FRAME, 1'b0, 1'b0, 32'h33, 32'h5A);
        idle_edges("wr2_end", 2);

        run_frame("mix", FRAME, 1'b1, 1'b0, 32'h0C, 32'h1234);
        idle_edges("mix_end", 1);

        for (int t = 0; t < 4; t++) begin
            logic [31:0] ra, rd;
            bit          rwa, rwb;
            ra  = $urandom;
            rd  = $urandom;
            rwa = 1'($urandom_range(0, 1));
            rwb = 1'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", t), FRAME, rwa, rwb, ra, rd);
            idle_edges($sformatf("rnd%0d_end", t), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
